serial_subtractor: RTL

- Bit-serial WIDTH-bit subtractor, computes diff = a - b.
- Processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- Start/busy/done handshake; produces difference, borrow-out and zero flag.
- Inverse-operation counterpart to the team's combinational ripple adder; used where area matters more than latency.

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             z
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             a0, b0, d_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  assign a0    = a_sh_q[0];
  assign b0    = b_sh_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;

  // Next-state, datapath shift and output-load decisions.
  // SHIFT spends WIDTH edges shifting and one more edge loading results.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    z_d      = z_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          diff_d   = res_q;
          borrow_d = br_q;
          z_d      = (res_q == '0);
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) &&
                     (res_q[WIDTH-1] != a_msb_q);
`endif
        end else begin
          res_d  = {d_bit, res_q[WIDTH-1:1]};
          br_d   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign z      = z_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf    = ovf_q;
`endif

endmodule
